// File: rtl/alu_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pipe
// Registered ALU-control decode stage with a 2-entry skid buffer.
// Decodes RV32I opcode/funct3/funct7 (plus RV32M when the macro
// ALU_CTRL_RV32M_EN is defined) into a binary alu_op, flags illegal
// encodings, carries a sideband tag, and counts accepted illegal entries.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous discard of both buffered entries
//   in_valid/in_ready upstream handshake (in_ready = skid entry empty)
//   op, f3, f7        instruction fields
//   in_tag            sideband tag, passed unmodified
//   out_valid/out_ready downstream handshake
//   alu_op, illegal, out_tag  registered decode result
//   illegal_cnt       saturating count of accepted illegal entries
// Parameters: ALU_OP_W (>= 5), TAG_W, CNT_W.
// ---------------------------------------------------------------------------
module alu_ctrl_pipe #(
  parameter int ALU_OP_W = 5,
  parameter int TAG_W    = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          op,
  input  logic [2:0]          f3,
  input  logic [6:0]          f7,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic [TAG_W-1:0]    out_tag,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU  = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_PASSB = 5'd10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Shared funct3 mapping for the f7=0000000 R-type and I-ALU forms.
  function automatic logic [4:0] f3_to_op(input logic [2:0] f);
    case (f)
      3'b000:  f3_to_op = OP_ADD;
      3'b001:  f3_to_op = OP_SLL;
      3'b010:  f3_to_op = OP_SLT;
      3'b011:  f3_to_op = OP_SLTU;
      3'b100:  f3_to_op = OP_XOR;
      3'b101:  f3_to_op = OP_SRL;
      3'b110:  f3_to_op = OP_OR;
      default: f3_to_op = OP_AND;
    endcase
  endfunction

  // ---------------- combinational decode of the incoming fields ----------
  logic [4:0] dec_code;
  logic       dec_ill;

  always_comb begin
    dec_code = OP_ADD;
    dec_ill  = 1'b0;
    case (op)
      7'b0110011: begin
        if (f7 == F7_BASE)                     dec_code = f3_to_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) dec_code = OP_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) dec_code = OP_SRA;
`ifdef ALU_CTRL_RV32M_EN
        else if (f7 == 7'b0000001)             dec_code = {2'b10, f3};
`endif
        else                                   dec_ill  = 1'b1;
      end
      7'b0010011: begin
        case (f3)
          3'b001: begin
            if (f7 == F7_BASE) dec_code = OP_SLL;
            else               dec_ill  = 1'b1;
          end
          3'b101: begin
            if (f7 == F7_BASE)     dec_code = OP_SRL;
            else if (f7 == F7_ALT) dec_code = OP_SRA;
            else                   dec_ill  = 1'b1;
          end
          default: dec_code = f3_to_op(f3);
        endcase
      end
      7'b0000011, 7'b0100011, 7'b0010111, 7'b1101111: dec_code = OP_ADD;
      7'b1100111: dec_ill  = (f3 != 3'b000);
      7'b1100011: dec_code = OP_SUB;
      7'b0110111: dec_code = OP_PASSB;
      default:    dec_ill  = 1'b1;
    endcase
  end

  // ---------------- skid buffer state ------------------------------------
  logic                out_valid_q, out_valid_d;
  logic [ALU_OP_W-1:0] out_op_q,    out_op_d;
  logic                out_ill_q,   out_ill_d;
  logic [TAG_W-1:0]    out_tag_q,   out_tag_d;
  logic                skid_valid_q, skid_valid_d;
  logic [ALU_OP_W-1:0] skid_op_q,   skid_op_d;
  logic                skid_ill_q,  skid_ill_d;
  logic [TAG_W-1:0]    skid_tag_q,  skid_tag_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  logic                accept;
  logic                out_free;
  logic [ALU_OP_W-1:0] new_op;

  // Flush drops a same-cycle input, so it never counts as accepted.
  assign accept   = in_valid && !skid_valid_q && !flush;
  // Output register can take a new entry if empty or draining this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign new_op   = ALU_OP_W'(dec_code);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_op_d     = out_op_q;
    out_ill_d    = out_ill_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    cnt_d        = cnt_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // Skid holds the older entry; in_ready was low so nothing new arrives.
        out_valid_d  = 1'b1;
        out_op_d     = skid_op_q;
        out_ill_d    = skid_ill_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_op_d  = new_op;
          out_ill_d = dec_ill;
          out_tag_d = in_tag;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_op_d    = new_op;
      skid_ill_d   = dec_ill;
      skid_tag_d   = in_tag;
    end

    if (accept && dec_ill && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_op_q     <= '0;
      out_ill_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= '0;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_ill_q    <= out_ill_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = out_valid_q;
  assign alu_op      = out_op_q;
  assign illegal     = out_ill_q;
  assign out_tag     = out_tag_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Testbench for alu_ctrl_pipe: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_alu_ctrl_pipe;

  localparam int TB_CNT_W = 4;   // small counter so saturation is reachable
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef ALU_CTRL_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, flush, in_valid, out_ready;
  logic [6:0]          op, f7;
  logic [2:0]          f3;
  logic [31:0]         in_tag;
  logic                in_ready, out_valid, illegal;
  logic [4:0]          alu_op;
  logic [31:0]         out_tag;
  logic [TB_CNT_W-1:0] illegal_cnt;

  alu_ctrl_pipe #(.ALU_OP_W(5), .TAG_W(32), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .f3(f3), .f7(f7), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .illegal(illegal), .out_tag(out_tag),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          code;
    bit          ill;
    logic [31:0] tag;
    int          id;
  } ent_t;

  localparam int R_TAB [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  function automatic void ref_dec(input logic [6:0] o, input logic [2:0] a,
                                  input logic [6:0] b, output int code, output bit ill);
    code = 0;
    ill  = 1'b0;
    if (o == 7'h33) begin
      if (b == 7'h00)                   code = R_TAB[a];
      else if (b == 7'h20 && a == 3'd0) code = 1;
      else if (b == 7'h20 && a == 3'd5) code = 7;
      else if (M_EN && b == 7'h01)      code = 16 + int'(a);
      else                              ill  = 1'b1;
    end else if (o == 7'h13) begin
      if (a == 3'd1 && b != 7'h00)      ill  = 1'b1;
      else if (a == 3'd5 && b == 7'h20) code = 7;
      else if (a == 3'd5 && b != 7'h00) ill  = 1'b1;
      else                              code = R_TAB[a];
    end else if (o == 7'h03 || o == 7'h23 || o == 7'h17 || o == 7'h6f) begin
      code = 0;
    end else if (o == 7'h67) begin
      ill = (a != 3'd0);
    end else if (o == 7'h63) begin
      code = 1;
    end else if (o == 7'h37) begin
      code = 10;
    end else begin
      ill = 1'b1;
    end
  endfunction

  ent_t        mq[$];
  int          mcnt = 0;
  int          next_id = 0;
  int          last_id = -1;
  bit          rec_on = 1'b0;
  logic [31:0] seen[$];

  // Model update on each edge: FIFO of depth 2, pop on drain, push on accept.
  initial begin
    ent_t e;
    bit   can_take;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        mcnt = 0;
      end else if (flush) begin
        mq.delete();
      end else begin
        can_take = (mq.size() < 2);
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && can_take) begin
          ref_dec(op, f3, f7, e.code, e.ill);
          e.tag = in_tag;
          e.id  = next_id++;
          mq.push_back(e);
          if (e.ill && mcnt < CNT_MAX) mcnt++;
        end
      end
    end
  end

  // Compare process: every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
      chk("illegal_cnt", 64'(illegal_cnt), 64'(mcnt));
      if (mq.size() > 0 && out_valid) begin
        chk("alu_op", 64'(alu_op), 64'(mq[0].code));
        chk("illegal", {63'd0, illegal}, {63'd0, mq[0].ill});
        chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
        if (mq[0].id != last_id) begin
          last_id = mq[0].id;
          if (rec_on) seen.push_back(out_tag);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic v, input logic [6:0] o, input logic [2:0] a,
                     input logic [6:0] b, input logic [31:0] t);
    in_valid = v; op = o; f3 = a; f7 = b; in_tag = t;
  endtask

  // Hold an entry until accepted (in_ready is stable between edges).
  task automatic send(input logic [6:0] o, input logic [2:0] a,
                      input logic [6:0] b, input logic [31:0] t);
    bit ok;
    int guard;
    put(1'b1, o, a, b, t);
    guard = 0;
    do begin
      ok = in_ready;
      @(negedge clk);
      guard++;
    end while (!ok && guard < 40);
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h17,
                                      7'h6f, 7'h67, 7'h63, 7'h37, 7'h0b};
  localparam logic [6:0] F7S [4]  = '{7'h00, 7'h20, 7'h01, 7'h7f};

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    put(1'b0, 7'd0, 3'd0, 7'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_cnt", 64'(illegal_cnt), 64'd0);
    rst = 1'b0;

    // Directed decode, one entry per cycle with out_ready high.
    put(1'b1, 7'h33, 3'b000, 7'h20, 32'h1); @(negedge clk);
    chk("sub_valid", {63'd0, out_valid}, 64'd1);
    chk("sub_op", 64'(alu_op), 64'd1);
    chk("sub_ill", {63'd0, illegal}, 64'd0);
    put(1'b1, 7'h33, 3'b101, 7'h20, 32'h2); @(negedge clk);
    chk("sra_op", 64'(alu_op), 64'd7);
    put(1'b1, 7'h13, 3'b001, 7'h20, 32'h3); @(negedge clk);
    chk("islli_bad_ill", {63'd0, illegal}, 64'd1);
    chk("islli_bad_op", 64'(alu_op), 64'd0);
    put(1'b1, 7'h7f, 3'b000, 7'h00, 32'h4); @(negedge clk);
    chk("badop_ill", {63'd0, illegal}, 64'd1);
    chk("badop_op", 64'(alu_op), 64'd0);
    chk("cnt_two", 64'(illegal_cnt), 64'd2);
    put(1'b1, 7'h37, 3'b000, 7'h00, 32'h5); @(negedge clk);
    chk("lui_op", 64'(alu_op), 64'd10);
    chk("lui_ill", {63'd0, illegal}, 64'd0);
    put(1'b1, 7'h33, 3'b100, 7'h01, 32'h6); @(negedge clk);
`ifdef ALU_CTRL_RV32M_EN
    chk("mdiv_op", 64'(alu_op), 64'd20);
    chk("mdiv_ill", {63'd0, illegal}, 64'd0);
`else
    chk("mdiv_op", 64'(alu_op), 64'd0);
    chk("mdiv_ill", {63'd0, illegal}, 64'd1);
`endif
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Back-pressure stream: tags 0x10..0x13 must emerge in order.
    seen.delete();
    rec_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send(7'h33, 3'b000, 7'h00, 32'h10 + 32'(i));
      end
      begin
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        chk("skid_full_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    rec_on = 1'b0;
    chk("stream_count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk($sformatf("stream_tag%0d", i), 64'(seen[i]), 64'h10 + 64'(i));

    // Flush with both entries full and a same-cycle illegal input.
    out_ready = 1'b0;
    send(7'h33, 3'b000, 7'h00, 32'h20);
    send(7'h33, 3'b110, 7'h00, 32'h21);
    chk("pre_flush_in_ready", {63'd0, in_ready}, 64'd0);
    put(1'b1, 7'h7f, 3'b000, 7'h00, 32'h22);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(7'h33, 3'b101, 7'h20, 32'h30);
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_alu_op", 64'(alu_op), 64'd0);
    chk("arst_illegal", {63'd0, illegal}, 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    chk("arst_cnt", 64'(illegal_cnt), 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Randomized traffic; the illegal counter saturates along the way.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = ($urandom_range(0, 15) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 9)];
      f3        = 3'($urandom);
      f7        = ($urandom_range(0, 7) == 0) ? 7'($urandom) : F7S[$urandom_range(0, 3)];
      in_tag    = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Registered, handshaked ALU-control decode stage that maps RV32I (optionally RV32M) opcode/funct3/funct7 onto a one-hot-free binary `alu_op`, flags illegal encodings, and carries a sideband tag. It sits between fetch/decode and execute, replacing purely combinational op generation. A 2-entry skid buffer gives full throughput under downstream back-pressure.

## Interface
- `ALU_OP_W`, 5: width of `alu_op`; must be ≥5.
- `TAG_W`, 32: width of the sideband tag (normally PC).
- `CNT_W`, 16: width of the saturating illegal-instruction counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous; discards all buffered entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept; equals skid entry empty.
- `op`, `f3`, `f7`  in  7/3/7  instruction fields.
- `in_tag`  in  `TAG_W`  sideband, passed unmodified.
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  downstream accepts.
- `alu_op`  out  `ALU_OP_W`  decoded operation.
- `illegal`  out  1  encoding not supported.
- `out_tag`  out  `TAG_W`  tag aligned with `alu_op`.
- `illegal_cnt`  out  `CNT_W`  illegal entries accepted since reset.

## Operation
- Codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10; M codes 16–23 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU); upper bits zero.
- R (0110011): f7=0000000 → f3 maps ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; f7=0100000 with f3=000 → SUB, f3=101 → SRA.
- I-ALU (0010011): f3 maps ADD/SLL/SLT/SLTU/XOR/SRL-SRA/OR/AND; f3=001 requires f7=0000000; f3=101 f7=0000000 → SRL, 0100000 → SRA.
- LOAD 0000011, STORE 0100011, AUIPC 0010111, JAL 1101111 → ADD; JALR 1100111 (f3=000) → ADD; BRANCH 1100011 → SUB; LUI 0110111 → PASSB.
- Anything else: `illegal`=1, `alu_op`=ADD. `illegal` is never set for a legal encoding.
- Skid buffer: main output register plus one skid register. Accept when `in_valid && in_ready`; accepted entry goes to output register if it is empty or drained the same cycle, else to skid. Skid refills output when output drains.
- `illegal_cnt` increments on each accepted illegal entry; saturates at all-ones.
- `flush`: both entries invalidated next edge; a same-cycle input is dropped and not counted; `illegal_cnt` is kept.

## Timing
- Latency 1 cycle: accepted at edge N → `out_valid` at N+1 when the output was empty.
- Throughput 1/cycle with `out_ready` high.
- `alu_op`, `illegal`, `out_tag` stable while `out_valid && !out_ready`.
- `in_ready` is registered state only, with no combinational path from `out_ready`.
- Ordering is strictly FIFO; no entry is lost or duplicated when back-pressure and input coincide.
- Reset (any time, including mid-transfer): `out_valid` 0, `alu_op` 0, `illegal` 0, `out_tag` 0, `illegal_cnt` 0, skid empty, `in_ready` 1 while `rst` is high and after release.

## Configuration
- `ALU_CTRL_RV32M_EN` defined: R with f7=0000001 decodes f3 000–111 to codes 16–23, legal.
- Not defined: f7=0000001 is illegal → ADD, `illegal`=1.

## Test plan
- R f3=000 f7=0100000, `out_ready`=1 → next cycle `out_valid`=1, `alu_op`=1, `illegal`=0; f3=101 f7=0100000 → `alu_op`=7.
- I-ALU f3=001 f7=0100000, then op=1111111 → both `illegal`=1 with `alu_op`=0; `illegal_cnt`=2; LUI → `alu_op`=10.
- Stream 4 tagged entries (tags 0x10–0x13), hold `out_ready`=0 for 3 cycles after first → `in_ready` falls after 2 buffered; on release, tags emerge 0x10..0x13 in order with none lost.
- `flush` while both entries are full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, dropped input is not seen and not counted.
- Assert `rst` mid-stream with `out_valid`=1 → outputs immediately 0, `illegal_cnt`=0.
- R f7=0000001 f3=100: with `ALU_CTRL_RV32M_EN` → `alu_op`=20, `illegal`=0; without it → `alu_op`=0, `illegal`=1.
